video_shifter: RTL and testbench
================================

VIDEO_SHIFTER -- requirements
Module: video_shifter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the width of one fetched video word.
REQ-002 SHALL have parameter BPP, default 1, meaning bits per pixel; legal values 1, 2, 4, and BPP must divide DATA_W.
REQ-003 SHALL have parameter DIV_W, default 4, meaning the width of the pixel-period register.
REQ-004 SHALL have parameter DEPTH, default 2, meaning the FIFO depth in words; power of 2, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port load, input, 1 bit: a pulse meaning load_data is a valid fetched video word.
REQ-008 SHALL have port load_data, input, DATA_W bits: the fetched video word.
REQ-009 SHALL have port sync, input, 1 bit: high means active display, low means blanking.
REQ-010 SHALL have port div, input, DIV_W bits: the pixel period minus 1, in clocks.
REQ-011 SHALL have port pixel, output, BPP bits: the current pixel value, 0 when not in RUN.
REQ-012 SHALL have port full, output, 1 bit: the FIFO holds DEPTH words.
REQ-013 SHALL have port underflow, output, 1 bit: sticky underflow flag.
REQ-014 SHALL have port urun_cnt, output, 8 bits: the underflow event counter.

Function
REQ-015 The FIFO SHALL accept load when not full; a push on a full FIFO with no pop in the same cycle SHALL be dropped.
REQ-016 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full or empty.
REQ-017 A word pushed at edge t SHALL be eligible for pop at edge t+1; there is no bypass path.
REQ-018 The state machine SHALL have states BLANK, WAIT and RUN.
REQ-019 In BLANK, pixel SHALL be 0, the divider SHALL be held, the FIFO SHALL be retained, and loads SHALL still be accepted.
REQ-020 From BLANK with sync high: if the FIFO is non-empty, the block SHALL pop into the shifter and go to RUN; if empty, it SHALL go to WAIT and flag underflow.
REQ-021 In RUN, pixel SHALL equal the top BPP bits of the shifter, and each pixel SHALL be held for div+1 clocks.
REQ-022 At divider terminal count in RUN, the shifter SHALL shift left by BPP, filling with 0.
REQ-023 After DATA_W/BPP pixels, if the FIFO is non-empty, the block SHALL pop the next word at the same edge, with no gap pixel.
REQ-024 After DATA_W/BPP pixels with the FIFO empty, the block SHALL go to WAIT, set pixel to 0, and count one underflow event.
REQ-025 In WAIT, when the FIFO becomes non-empty, the block SHALL pop, restart the divider at div, and go to RUN.
REQ-026 Whenever sync is low, the block SHALL go to BLANK on the next edge from any state; a partially shifted word SHALL be discarded.
REQ-027 A change of div SHALL take effect at the next divider reload only.
REQ-028 urun_cnt SHALL saturate at 255.
REQ-029 underflow SHALL be set by any underflow event and cleared only by reset.

Reset
REQ-030 While reset is low, the state SHALL be BLANK, the FIFO empty, the shifter 0, the divider 0, pixel 0, full 0, underflow 0 and urun_cnt 0.
REQ-031 Reset SHALL be asserted asynchronously and released synchronously to clk.
REQ-032 Reset mid-word SHALL discard all buffered pixels.

Configuration
REQ-033 With macro VIDEO_SHIFTER_STATS_EN defined, underflow and urun_cnt SHALL behave per REQ-024, REQ-028 and REQ-029.
REQ-034 Without VIDEO_SHIFTER_STATS_EN, underflow and urun_cnt SHALL be tied to 0, their logic SHALL be absent, and the ports SHALL remain present.

Structure
REQ-035 The state encoding and the BPP legality check constant SHALL live in shared package video_pkg.
REQ-036 The FIFO SHALL be sub-module video_fifo, parametrised by DATA_W and DEPTH, providing push, pop, full and empty.

Verification
REQ-037 Scenario, div=0, BPP=1: load 0xA5 with sync high -> pixel sequence 1,0,1,0,0,1,0,1, one clock each, starting one clock after the pop.
REQ-038 Scenario, div=1, BPP=2, back-to-back words 0x1B then 0xE4 -> pixel 0,1,2,3,3,2,1,0, each held 2 clocks, with no gap between the words.
REQ-039 Scenario, no second word available -> pixel 0 after the 8th pixel, underflow=1, urun_cnt=1; a later load returns to RUN one clock after the push.
REQ-040 Scenario, DEPTH=2, three loads with no pop -> full=1 and the third word is dropped; a simultaneous load and pop while full keeps full=1 with no loss.
REQ-041 Scenario, sync dropped mid-word -> pixel=0 on the next edge and the remaining bits are discarded; the FIFO contents survive and the next word starts on the sync rise.
REQ-042 Scenario, reset pulsed low in RUN -> all outputs 0 immediately; build without VIDEO_SHIFTER_STATS_EN -> underflow and urun_cnt stay 0 during the REQ-039 stimulus.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: FSM state encoding and parameter legality check shared by the video shifter.
package video_pkg;
  localparam logic [1:0] ST_BLANK = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  function automatic bit bpp_legal(int bpp, int data_w);
    return (bpp == 1 || bpp == 2 || bpp == 4) && (data_w % bpp == 0);
  endfunction
endpackage

// File: rtl/video_fifo.sv
// video_fifo: word FIFO; push on full is dropped unless a pop happens in the same cycle.
module video_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty   = wr_q == rd_q;
  assign full    = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/video_shifter.sv
// video_shifter: FIFO-fed pixel serialiser with BLANK/WAIT/RUN control.
// Define VIDEO_SHIFTER_STATS_EN to build the underflow flag and underrun counter.
module video_shifter
  import video_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BPP    = 1,
  parameter int DIV_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              sync,
  input  logic [DIV_W-1:0]  div,
  output logic [BPP-1:0]    pixel,
  output logic              full,
  output logic              underflow,
  output logic [7:0]        urun_cnt
);
  localparam int PIX_N = bpp_legal(BPP, DATA_W) ? DATA_W / BPP : 1;
  localparam int CW = $clog2(PIX_N + 1);
  localparam logic [CW-1:0] PIX_LAST = CW'(PIX_N - 1);
  logic [1:0] state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, fifo_dout;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic empty, pop, tc, last;
  video_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(load), .pop(pop), .din(load_data),
    .dout(fifo_dout), .full(full), .empty(empty)
  );
  assign tc    = div_cnt_q == '0;
  assign last  = tc && pix_cnt_q == '0;
  assign pixel = state_q == ST_RUN ? shift_q[DATA_W-1 -: BPP] : '0;
  // The last pixel of a word and a fresh word share one edge, so there is no gap pixel.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    div_cnt_d = div_cnt_q;
    pix_cnt_d = pix_cnt_q;
    pop       = 1'b0;
    if (!sync) begin
      state_d   = ST_BLANK;
      shift_d   = '0;
      pix_cnt_d = '0;
    end else if (state_q == ST_RUN && !last) begin
      div_cnt_d = tc ? div : div_cnt_q - 1'b1;
      shift_d   = tc ? shift_q << BPP : shift_q;
      pix_cnt_d = tc ? pix_cnt_q - 1'b1 : pix_cnt_q;
    end else if (!empty) begin
      pop       = 1'b1;
      state_d   = ST_RUN;
      shift_d   = fifo_dout;
      div_cnt_d = div;
      pix_cnt_d = PIX_LAST;
    end else begin
      state_d   = ST_WAIT;
      shift_d   = '0;
      pix_cnt_d = '0;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= ST_BLANK;
      shift_q   <= '0;
      div_cnt_q <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      div_cnt_q <= div_cnt_d;
      pix_cnt_q <= pix_cnt_d;
    end
`ifdef VIDEO_SHIFTER_STATS_EN
  logic urun_ev, under_q;
  logic [7:0] cnt_q;
  assign urun_ev = sync && empty && (state_q == ST_BLANK || (state_q == ST_RUN && last));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      under_q <= 1'b0;
      cnt_q   <= '0;
    end else if (urun_ev) begin
      under_q <= 1'b1;
      cnt_q   <= cnt_q + {7'd0, cnt_q != 8'hff};
    end
  assign underflow = under_q;
  assign urun_cnt  = cnt_q;
`else
  assign underflow = 1'b0;
  assign urun_cnt  = 8'd0;
`endif
endmodule

// File: tb/tb_video_shifter.sv
// tb_video_shifter: timestamped scoreboard of expected outputs, checked by a negedge monitor.
module tb_video_shifter;
  localparam int PIX = 0, FUL = 1, UND = 2, CNT = 3;
`ifdef VIDEO_SHIFTER_STATS_EN
  localparam int U = 1;
`else
  localparam int U = 0;
`endif
  typedef struct packed { int cyc; int dut; int fld; int val; int tag; } sb_t;
  sb_t sb[$];
  string fname [4] = '{"pixel", "full", "underflow", "urun_cnt"};
  logic clk = 1'b0, reset = 1'b0, load = 1'b0, sync = 1'b0;
  logic [7:0] load_data = '0;
  logic [3:0] div = '0;
  logic pix1, full1, und1, full2, und2;
  logic [1:0] pix2;
  logic [7:0] cnt1, cnt2;
  int cyc = 0, checks = 0, fails = 0, ntag = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  video_shifter #(.DATA_W(8), .BPP(1), .DIV_W(4), .DEPTH(2)) dut1 (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data), .sync(sync), .div(div),
    .pixel(pix1), .full(full1), .underflow(und1), .urun_cnt(cnt1));
  video_shifter #(.DATA_W(8), .BPP(2), .DIV_W(4), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data), .sync(sync), .div(div),
    .pixel(pix2), .full(full2), .underflow(und2), .urun_cnt(cnt2));
  function automatic int actual(int d, int f);
    if (d == 1) return f == PIX ? int'(pix1) : f == FUL ? int'(full1) : f == UND ? int'(und1) : int'(cnt1);
    return f == PIX ? int'(pix2) : f == FUL ? int'(full2) : f == UND ? int'(und2) : int'(cnt2);
  endfunction
  function automatic void exp_at(int dc, int d, int f, int v);
    sb_t e;
    int i;
    e = '{cyc: cyc + dc, dut: d, fld: f, val: v, tag: ntag};
    ntag++;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > e.cyc) i--;
    sb.insert(i, e);
  endfunction
  function automatic void exp_word(int dc, int d, int hold, logic [7:0] w, int bpp);
    for (int i = 0; i < 8 / bpp; i++)
      for (int h = 0; h < hold; h++)
        exp_at(dc + i * hold + h, d, PIX, int'(w >> (8 - bpp * (i + 1))) & ((1 << bpp) - 1));
  endfunction
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    sb_t e;
    int a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = actual(e.dut, e.fld);
      checks++;
      if (e.cyc != cyc) begin
        fails++;
        $display("FAIL dut%0d.%s #%0d: sample for cycle %0d missed (now %0d)", e.dut, fname[e.fld], e.tag, e.cyc, cyc);
      end else if (a != e.val) begin
        fails++;
        $display("FAIL dut%0d.%s #%0d at cycle %0d: got %0d, expected %0d", e.dut, fname[e.fld], e.tag, cyc, a, e.val);
      end
    end
  end
  initial begin
    step();
    exp_at(0, 1, PIX, 0); exp_at(0, 1, FUL, 0); exp_at(0, 1, UND, 0); exp_at(0, 1, CNT, 0);
    exp_at(0, 2, PIX, 0); exp_at(0, 2, FUL, 0);
    step();
    reset = 1'b1;
    step();
    // single word 0xA5 at div=0, then underrun, then a late word
    load = 1'b1; load_data = 8'hA5;
    step();
    load = 1'b0; sync = 1'b1;
    exp_word(1, 1, 1, 8'hA5, 1);
    exp_at(9, 1, PIX, 0); exp_at(9, 1, UND, U); exp_at(9, 1, CNT, U);
    step(12);
    load = 1'b1; load_data = 8'hC3;
    step();
    load = 1'b0;
    exp_at(0, 1, PIX, 0);
    exp_word(1, 1, 1, 8'hC3, 1);
    exp_at(9, 1, PIX, 0); exp_at(9, 1, UND, U); exp_at(9, 1, CNT, 2 * U);
    step(12);
    // BPP=2, div=1, back-to-back words
    sync = 1'b0; div = 4'd1; load = 1'b1; load_data = 8'h1B;
    step();
    load_data = 8'hE4;
    step();
    load = 1'b0; sync = 1'b1;
    exp_at(0, 2, FUL, 1); exp_at(1, 2, FUL, 0);
    exp_word(1, 2, 2, 8'h1B, 2); exp_word(9, 2, 2, 8'hE4, 2);
    exp_at(17, 2, PIX, 0);
    step(20);
    // fill, dropped third push, push+pop while full
    sync = 1'b0; div = 4'd0; load = 1'b1; load_data = 8'h81;
    step();
    load_data = 8'h42;
    step();
    load_data = 8'hFF;
    exp_at(0, 1, FUL, 1);
    step();
    load_data = 8'h24; sync = 1'b1;
    exp_at(0, 1, FUL, 1);
    step();
    load = 1'b0;
    exp_at(0, 1, FUL, 1);
    exp_word(0, 1, 1, 8'h81, 1);
    exp_at(8, 1, FUL, 0);
    exp_word(8, 1, 1, 8'h42, 1);
    exp_word(16, 1, 1, 8'h24, 1);
    exp_at(24, 1, PIX, 0);
    step(26);
    // sync dropped mid-word
    sync = 1'b0; load = 1'b1; load_data = 8'hF0;
    step();
    load_data = 8'h0F;
    step();
    load = 1'b0; sync = 1'b1;
    exp_at(1, 1, PIX, 1); exp_at(2, 1, PIX, 1);
    step(2);
    sync = 1'b0;
    exp_at(1, 1, PIX, 0); exp_at(2, 1, PIX, 0); exp_at(2, 1, FUL, 0);
    step(2);
    sync = 1'b1;
    exp_word(1, 1, 1, 8'h0F, 1);
    exp_at(9, 1, PIX, 0);
    step(10);
    // div change lands only at the next reload
    div = 4'd2; load = 1'b1; load_data = 8'hAA;
    step();
    load = 1'b0;
    exp_at(1, 1, PIX, 1); exp_at(2, 1, PIX, 1); exp_at(3, 1, PIX, 1);
    for (int i = 0; i < 7; i++) exp_at(4 + i, 1, PIX, (i % 2 == 0) ? 0 : 1);
    exp_at(11, 1, PIX, 0);
    step();
    div = 4'd0;
    step(12);
    // asynchronous reset while running with a full FIFO
    load = 1'b1; load_data = 8'hFF;
    step(3);
    load = 1'b0;
    exp_at(0, 1, FUL, 1); exp_at(0, 1, PIX, 1);
    step();
    reset = 1'b0; sync = 1'b0;
    exp_at(0, 1, PIX, 0); exp_at(0, 1, FUL, 0); exp_at(0, 1, UND, 0); exp_at(0, 1, CNT, 0);
    exp_at(0, 2, PIX, 0); exp_at(0, 2, FUL, 0);
    step();
    #2 reset = 1'b1; sync = 1'b1;
    exp_at(1, 1, PIX, 0); exp_at(1, 1, FUL, 0); exp_at(3, 1, PIX, 0);
    for (int i = 0; i < 50 && sb.size() > 0; i++) step();
    while (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      checks++;
      fails++;
      $display("FAIL dut%0d.%s #%0d: never sampled (cycle %0d)", e.dut, fname[e.fld], e.tag, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
